// File: rtl/pim_req_responder.sv
// Open-page PIM line responder: one request at a time; latency T_CL (hit), T_RCD+T_CL (closed), T_RP+T_RCD+T_CL (conflict).
// req_ready only in IDLE; RESP holds resp_data and every counter until resp_ready.
module pim_req_responder #(
   parameter int T_RP  = 4,
   parameter int T_RCD = 4,
   parameter int T_CL  = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [31:0]  req_addr,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [511:0] resp_data,
   output logic [31:0]  act_count,
   output logic [31:0]  rd_count,
   output logic [31:0]  pre_count,
   output logic [31:0]  hit_count
);

   typedef enum logic [2:0] {IDLE, PRE, ACT, RD, RESP} state_t;

   state_t       state_q, state_d;
   logic [7:0]   wait_q;
   logic [2:0]   bank_q;
   logic [12:0]  row_lat_q;
   logic [7:0]   open_q;
   logic [12:0]  open_row_q [8];

   logic [2:0]   req_bank, cur_bank;
   logic [12:0]  req_row, cur_row;
   logic         row_hit, accept;
   logic         enter_pre, enter_act, enter_rd;
   logic [31:0]  line_base;
   logic [511:0] line_d;

   always_comb begin
      req_bank  = req_addr[12:10];
      req_row   = req_addr[25:13];
      // ACT/PRE can be entered straight from IDLE, before the address is latched
      cur_bank  = (state_q == IDLE) ? req_bank : bank_q;
      cur_row   = (state_q == IDLE) ? req_row  : row_lat_q;
      row_hit   = open_q[req_bank] && (open_row_q[req_bank] == req_row);
      req_ready = (state_q == IDLE);
      resp_valid = (state_q == RESP);
      accept    = req_valid && (state_q == IDLE);

      state_d = state_q;
      case (state_q)
         IDLE: if (req_valid) begin
            if (row_hit)                state_d = RD;
            else if (!open_q[req_bank]) state_d = ACT;
            else                        state_d = PRE;
         end
         PRE:  if (wait_q == 8'd0) state_d = ACT;
         ACT:  if (wait_q == 8'd0) state_d = RD;
         RD:   if (wait_q == 8'd0) state_d = RESP;
         RESP: if (resp_ready)     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      enter_pre = (state_d == PRE) && (state_q != PRE);
      enter_act = (state_d == ACT) && (state_q != ACT);
      enter_rd  = (state_d == RD)  && (state_q != RD);

      line_base = req_addr & 32'hFFFF_FFC0;
      line_d    = '0;
      for (int i = 0; i < 16; i++) begin
         line_d[32*i +: 32] = line_base + 32'(4 * i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wait_q    <= 8'd0;
         bank_q    <= 3'd0;
         row_lat_q <= 13'd0;
         open_q    <= 8'd0;
         for (int b = 0; b < 8; b++) open_row_q[b] <= 13'd0;
         resp_data <= '0;
         act_count <= 32'd0;
         rd_count  <= 32'd0;
         pre_count <= 32'd0;
         hit_count <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            bank_q    <= req_bank;
            row_lat_q <= req_row;
            resp_data <= line_d;
            if (row_hit) hit_count <= hit_count + 32'd1;
         end
         if (enter_pre) begin
            pre_count        <= pre_count + 32'd1;
            open_q[cur_bank] <= 1'b0;
            wait_q           <= 8'(T_RP - 1);
         end else if (enter_act) begin
            act_count            <= act_count + 32'd1;
            open_q[cur_bank]     <= 1'b1;
            open_row_q[cur_bank] <= cur_row;
            wait_q               <= 8'(T_RCD - 1);
         end else if (enter_rd) begin
            rd_count <= rd_count + 32'd1;
            wait_q   <= 8'(T_CL - 1);
         end else if (wait_q != 8'd0) begin
            wait_q <= wait_q - 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pim_req_responder.sv
// Randomized and directed bench for pim_req_responder against a bank/row reference model.
module tb_pim_req_responder;
   localparam int T_RP  = 4;
   localparam int T_RCD = 4;
   localparam int T_CL  = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [31:0]  req_addr = 32'd0;
   logic         resp_valid;
   logic         resp_ready = 1'b1;
   logic [511:0] resp_data;
   logic [31:0]  act_count, rd_count, pre_count, hit_count;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model: which row each bank holds open, and command statistics
   bit          m_open [8];
   logic [12:0] m_row  [8];
   logic [31:0] m_act, m_rd, m_pre, m_hit;

   pim_req_responder #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .act_count(act_count), .rd_count(rd_count),
      .pre_count(pre_count), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int b = 0; b < 8; b++) begin
         m_open[b] = 1'b0;
         m_row[b]  = 13'd0;
      end
      m_act = 0; m_rd = 0; m_pre = 0; m_hit = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
   endtask

   task automatic check_counters(input string tag);
      n_cmp++;
      if (act_count !== m_act || rd_count !== m_rd || pre_count !== m_pre || hit_count !== m_hit) begin
         n_fail++;
         $display("FAIL %s counters: act/rd/pre/hit got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                  tag, act_count, rd_count, pre_count, hit_count, m_act, m_rd, m_pre, m_hit);
      end
   endtask

   // one full transaction; bp = cycles of resp_ready=0 held while in RESP
   task automatic run_req(input logic [31:0] addr, input int bp, input string tag);
      int lat, exp_lat, guard;
      logic [2:0]   b;
      logic [12:0]  r;
      logic [31:0]  base;
      logic [511:0] exp_data;
      b = addr[12:10];
      r = addr[25:13];
      if (m_open[b] && m_row[b] == r) begin
         exp_lat = T_CL;
         m_hit++;
      end else if (!m_open[b]) begin
         exp_lat = T_RCD + T_CL;
         m_act++;
         m_open[b] = 1'b1; m_row[b] = r;
      end else begin
         exp_lat = T_RP + T_RCD + T_CL;
         m_pre++; m_act++;
         m_row[b] = r;
      end
      m_rd++;
      base = {addr[31:6], 6'b0};
      for (int i = 0; i < 16; i++) exp_data[32*i +: 32] = base + 32'(i * 4);

      guard = 0;
      while (req_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s req_ready_idle: got %b expected 1", tag, req_ready);
      end
      resp_ready = (bp == 0);
      req_valid = 1'b1; req_addr = addr;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 1000) begin
         @(posedge clk); #1; lat++;
      end
      n_cmp++;
      if (lat !== exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: addr %h got %0d cycles expected %0d", tag, addr, lat, exp_lat);
      end
      n_cmp++;
      if (resp_data !== exp_data) begin
         n_fail++;
         $display("FAIL %s resp_data: addr %h lane0 %h lane15 %h expected lane0 %h lane15 %h",
                  tag, addr, resp_data[31:0], resp_data[511:480], exp_data[31:0], exp_data[511:480]);
      end
      check_counters(tag);
      for (int k = 0; k < bp; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s backpressure hold: cycle %0d resp_valid %b req_ready %b data_ok %b",
                     tag, k, resp_valid, req_ready, resp_data === exp_data);
         end
         check_counters(tag);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s return_idle: resp_valid %b req_ready %b expected 0 1", tag, resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: resp_valid %b req_ready %b data_zero %b", resp_valid, req_ready, resp_data === '0);
      end
      model_clear();
      check_counters("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: req_ready %b resp_valid %b", req_ready, resp_valid);
      end
   endtask

   task automatic test_directed();
      do_reset();
      run_req(32'h0004_0000, 0, "closed");
      n_cmp++;
      if (act_count !== 32'd1 || rd_count !== 32'd1 || pre_count !== 32'd0 || hit_count !== 32'd0) begin
         n_fail++;
         $display("FAIL closed_const: act/rd/pre/hit %0d/%0d/%0d/%0d expected 1/1/0/0", act_count, rd_count, pre_count, hit_count);
      end
      run_req(32'h0004_0040, 0, "hit");
      n_cmp++;
      if (act_count !== 32'd1 || rd_count !== 32'd2 || hit_count !== 32'd1) begin
         n_fail++;
         $display("FAIL hit_const: act/rd/hit %0d/%0d/%0d expected 1/2/1", act_count, rd_count, hit_count);
      end
      run_req(32'h0004_2000, 0, "conflict");
      n_cmp++;
      if (act_count !== 32'd2 || rd_count !== 32'd3 || pre_count !== 32'd1) begin
         n_fail++;
         $display("FAIL conflict_const: act/rd/pre %0d/%0d/%0d expected 2/3/1", act_count, rd_count, pre_count);
      end
   endtask

   task automatic test_backpressure();
      run_req(32'h0004_2040, 20, "backpressure");
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 1'b1; req_addr = 32'h0004_0000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_abort: cycle %0d resp_valid %b req_ready %b", k, resp_valid, req_ready);
         end
      end
      check_counters("reset_abort");
      run_req(32'h0004_0000, 0, "after_abort");
   endtask

   task automatic test_stream();
      do_reset();
      for (int n = 0; n < 3000; n++) run_req(32'h0004_0000 + 32'(n * 64), 0, "stream");
      n_cmp++;
      if (rd_count !== 32'd3000 || act_count + hit_count !== 32'd3000) begin
         n_fail++;
         $display("FAIL stream_totals: rd %0d act+hit %0d expected 3000 3000", rd_count, act_count + hit_count);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         a[25:13] = 13'($urandom_range(0, 2));
         a[12:10] = 3'($urandom_range(0, 7));
         run_req(a, $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_stream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
